// File: rtl/sprite_arb_pkg.sv
// Shared sizing defaults and requester naming for the sprite ROM arbiter slice.
package sprite_arb_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned ADDR_W_DEF  = 12;
  localparam int unsigned DATA_W_DEF  = 4;

  typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_id_t;

  typedef enum logic [$clog2(NUM_REQ_DEF)-1:0] {
    REQ_PLAYER = 2'd0,
    REQ_ENEMY  = 2'd1,
    REQ_BLOCK  = 2'd2,
    REQ_BG     = 2'd3
  } req_name_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational rotating priority encoder: first asserted request at or after
// 'start' (wrapping) wins; returns one-hot grant, its index and an any flag.
module rr_picker #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] start,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any_gnt
);

  logic [N-1:0]  rot;
  logic [ID_W:0] off;
  logic [ID_W:0] sum;

  always_comb begin
    // Doubling the vector lets a plain right shift act as a rotate by 'start'.
    rot     = N'({req, req} >> start);
    any_gnt = 1'b0;
    off     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!any_gnt && rot[k]) begin
        any_gnt = 1'b1;
        off     = (ID_W+1)'(k);
      end
    end
    sum = {1'b0, start} + off;
    if (sum >= (ID_W+1)'(N)) sum = sum - (ID_W+1)'(N);
    gnt_id = sum[ID_W-1:0];
    gnt    = any_gnt ? (N'(1) << gnt_id) : '0;
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one registered-read sprite ROM port among NUM_REQ pixel fetchers and
// routes each read back by id. Define SPRITE_ARB_FIXED_PRIO_EN for fixed priority.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ROM_LAT = 1
) (
  input  logic                      vga_clk,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_q,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_id;
  logic               pick_any;
  logic [ID_W-1:0]    start_idx;
  logic               grant;

  logic [ROM_LAT-1:0]           pipe_vld_q, pipe_vld_d;
  logic [ROM_LAT-1:0][ID_W-1:0] pipe_id_q, pipe_id_d;
  logic [NUM_REQ-1:0]           rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]            rsp_data_q, rsp_data_d;

`ifdef SPRITE_ARB_FIXED_PRIO_EN
  assign start_idx = '0;
`else
  logic [ID_W-1:0] last_grant_q, last_grant_d;

  assign start_idx = (last_grant_q == ID_W'(NUM_REQ-1)) ? '0 : last_grant_q + 1'b1;

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant) last_grant_d = pick_id;
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) last_grant_q <= ID_W'(NUM_REQ-1);
    else       last_grant_q <= last_grant_d;
  end
`endif

  rr_picker #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_picker (
    .req     (req_valid),
    .start   (start_idx),
    .gnt     (pick_gnt),
    .gnt_id  (pick_id),
    .any_gnt (pick_any)
  );

  always_comb begin
    grant     = pick_any && !Reset;
    req_ready = grant ? pick_gnt : '0;
    rom_addr  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant && pick_gnt[i]) rom_addr = rom_addr | req_addr[i*ADDR_W +: ADDR_W];
    end

    pipe_vld_d    = '0;
    pipe_id_d     = '0;
    pipe_vld_d[0] = grant;
    pipe_id_d[0]  = pick_id;
    for (int unsigned s = 1; s < ROM_LAT; s++) begin
      pipe_vld_d[s] = pipe_vld_q[s-1];
      pipe_id_d[s]  = pipe_id_q[s-1];
    end

    // rom_q becomes valid exactly as the grant reaches the last stage.
    rsp_valid_d = pipe_vld_q[ROM_LAT-1] ? (NUM_REQ'(1) << pipe_id_q[ROM_LAT-1]) : '0;
    rsp_data_d  = pipe_vld_q[ROM_LAT-1] ? rom_q : rsp_data_q;
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      pipe_vld_q  <= '0;
      pipe_id_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      pipe_vld_q  <= pipe_vld_d;
      pipe_id_q   <= pipe_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = |pipe_vld_q;

endmodule
